// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds in-flight BHT predictions in program order,
// emits a one-cycle BHT update on each resolve, and on a mispredict discards
// wrong-path entries and holds fetch off for FLUSH_CYC cycles.
// Optional feature macro: BRQ_STATS_EN (saturating branch/mispredict counters).
module branch_resolve_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned HIST_W    = 2,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  input  logic [HIST_W-1:0]          pred_hist,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       upd_valid,
  output logic                       upd_outcome,
  output logic [HIST_W-1:0]          upd_hist,
  output logic                       mispredict,
  output logic                       flush,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       underflow,
  output logic [CNT_W-1:0]           branch_cnt,
  output logic [CNT_W-1:0]           mispred_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;
  localparam int unsigned FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state;
  logic [FW-1:0]     flush_cnt;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [DEPTH-1:0]  q_taken;
  logic [HIST_W-1:0] q_hist [DEPTH];

  logic push;
  logic pop;
  logic mis;
  logic do_push;

  // Handshake and resolve decode
  always_comb begin
    pred_ready = (state == RUN) && (occupancy < OW'(DEPTH));
    push       = pred_valid && pred_ready;
    pop        = res_valid && (occupancy != '0) && (state == RUN);
    mis        = pop && (q_taken[head] != res_taken);
    // A push in the mispredict cycle is on the wrong path and is dropped.
    do_push    = push && !mis;
  end

  // Entry storage, written at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      q_taken[tail] <= pred_taken;
      q_hist[tail]  <= pred_hist;
    end
  end

  // Pointers, occupancy, update strobe, underflow and RUN/FLUSH control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      flush_cnt   <= '0;
      flush       <= 1'b0;
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      upd_valid   <= 1'b0;
      upd_outcome <= 1'b0;
      upd_hist    <= '0;
      mispredict  <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      upd_valid   <= pop;
      upd_outcome <= pop && res_taken;
      upd_hist    <= pop ? q_hist[head] : '0;
      mispredict  <= mis;

      if (res_valid && (occupancy == '0) && (state == RUN))
        underflow <= 1'b1;

      if (mis) begin
        // Discard everything younger: the queue restarts empty just past head.
        head      <= head + PW'(1);
        tail      <= head + PW'(1);
        occupancy <= '0;
      end else begin
        if (pop)     head <= head + PW'(1);
        if (do_push) tail <= tail + PW'(1);
        occupancy <= occupancy + OW'(do_push) - OW'(pop);
      end

      case (state)
        RUN: begin
          if (mis) begin
            state     <= FLUSH;
            flush     <= 1'b1;
            flush_cnt <= FW'(FLUSH_CYC - 1);
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRQ_STATS_EN
  // Saturating resolve and mispredict counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (pop && (branch_cnt != '1))
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mis && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue using a queue-based reference
// model; covers reset, fill, correct path, mispredict/flush, push+pop,
// underflow, saturating stats, reset mid-flush and a randomized run.
module tb_branch_resolve_queue;

  localparam int DEPTH     = 4;
  localparam int HIST_W    = 2;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 2;
  localparam int CMAX      = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              pred_valid, pred_taken;
  logic [HIST_W-1:0] pred_hist;
  logic              pred_ready;
  logic              res_valid, res_taken;
  logic              upd_valid, upd_outcome;
  logic [HIST_W-1:0] upd_hist;
  logic              mispredict, flush;
  logic [2:0]        occupancy;
  logic              underflow;
  logic [CNT_W-1:0]  branch_cnt, mispred_cnt;

  branch_resolve_queue #(
    .DEPTH(DEPTH), .HIST_W(HIST_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_hist(pred_hist),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_outcome(upd_outcome), .upd_hist(upd_hist),
    .mispredict(mispredict), .flush(flush), .occupancy(occupancy),
    .underflow(underflow), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              taken;
    logic [HIST_W-1:0] hist;
  } ent_t;

  // Reference model state
  ent_t m_q[$];
  int   m_flush;
  bit   m_under;
  int   m_bcnt, m_mcnt;
  bit   e_upd_valid, e_upd_outcome, e_mis;
  logic [HIST_W-1:0] e_upd_hist;

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;

  function automatic bit m_ready();
    return (m_flush == 0) && (m_q.size() < DEPTH);
  endfunction

  function automatic int exp_bcnt();
`ifdef BRQ_STATS_EN
    return m_bcnt;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_mcnt();
`ifdef BRQ_STATS_EN
    return m_mcnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_flush = 0; m_under = 0; m_bcnt = 0; m_mcnt = 0;
    e_upd_valid = 0; e_upd_outcome = 0; e_mis = 0; e_upd_hist = '0;
  endtask

  // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge
  task automatic cycle(input bit pv, input bit pt, input logic [HIST_W-1:0] ph,
                       input bit rv, input bit rt);
    ent_t e;
    bit   rdy, mis;
    pred_valid = pv; pred_taken = pt; pred_hist = ph;
    res_valid  = rv; res_taken  = rt;
    rdy = m_ready();
    mis = 0;
    e_upd_valid = 0;
    if (rv) begin
      if (m_q.size() == 0) begin
        if (m_flush == 0) m_under = 1;
      end else begin
        e = m_q.pop_front();
        e_upd_valid   = 1;
        e_upd_outcome = rt;
        e_upd_hist    = e.hist;
        mis = (e.taken != rt);
        if (m_bcnt < CMAX) m_bcnt++;
        if (mis && m_mcnt < CMAX) m_mcnt++;
      end
    end
    e_mis = mis;
    if (m_flush > 0) m_flush--;
    if (mis) begin
      m_q.delete();
      m_flush = FLUSH_CYC;
    end else if (pv && rdy) begin
      m_q.push_back('{taken: pt, hist: ph});
    end
    @(posedge clk);
    #1;
    n_vec++;
    pred_valid = 0; res_valid = 0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_chk++; if (pred_ready !== 1'b1) begin n_err++; $display("FAIL rst_pred_ready got %b want 1", pred_ready); end
    n_chk++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
    n_chk++; if (upd_valid !== 1'b0 || mispredict !== 1'b0) begin n_err++; $display("FAIL rst_upd got %b/%b want 0/0", upd_valid, mispredict); end
    n_chk++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush got %b want 0", flush); end
    n_chk++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rst_underflow got %b want 0", underflow); end
    n_chk++; if (branch_cnt !== '0 || mispred_cnt !== '0) begin n_err++; $display("FAIL rst_counters got %0d/%0d want 0/0", branch_cnt, mispred_cnt); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    pred_valid = 0; pred_taken = 0; pred_hist = '0; res_valid = 0; res_taken = 0;
    reset = 1'b1;
    #12;
    reset = 1'b0;
    do_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 1, HIST_W'(i), 0, 0);
      n_chk++; if (occupancy !== 3'(m_q.size())) begin n_err++; $display("FAIL fill_occ[%0d] got %0d want %0d", i, occupancy, m_q.size()); end
    end
    n_chk++; if (pred_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %b want 0", pred_ready); end
    cycle(1, 0, 2'd3, 0, 0);
    n_chk++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL fill_5th_push occ got %0d want 4", occupancy); end
  endtask

  task automatic test_correct_path();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, '0, 1, 1);
      n_chk++; if (upd_valid !== 1'b1 || upd_hist !== e_upd_hist || upd_outcome !== 1'b1)
        begin n_err++; $display("FAIL correct_upd[%0d] got v%b h%0d o%b want v1 h%0d o1", i, upd_valid, upd_hist, upd_outcome, e_upd_hist); end
      n_chk++; if (upd_hist !== HIST_W'(i)) begin n_err++; $display("FAIL correct_order[%0d] got %0d want %0d", i, upd_hist, i); end
      n_chk++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL correct_mis[%0d] got %b want 0", i, mispredict); end
    end
    cycle(0, 0, '0, 0, 0);
    n_chk++; if (upd_valid !== 1'b0 || occupancy !== 3'd0) begin n_err++; $display("FAIL correct_idle got v%b occ%0d want v0 occ0", upd_valid, occupancy); end
  endtask

  task automatic test_mispredict();
    for (int i = 0; i < 3; i++) cycle(1, 0, 2'd2, 0, 0);
    cycle(1, 1, 2'd1, 1, 1);
    n_chk++; if (upd_valid !== 1'b1 || upd_hist !== 2'd2 || upd_outcome !== 1'b1 || mispredict !== 1'b1)
      begin n_err++; $display("FAIL mis_upd got v%b h%0d o%b m%b want v1 h2 o1 m1", upd_valid, upd_hist, upd_outcome, mispredict); end
    n_chk++; if (occupancy !== 3'd0 || flush !== 1'b1 || pred_ready !== 1'b0)
      begin n_err++; $display("FAIL mis_flush1 got occ%0d f%b r%b want occ0 f1 r0", occupancy, flush, pred_ready); end
    cycle(1, 1, 2'd1, 1, 1);
    n_chk++; if (flush !== 1'b1 || pred_ready !== 1'b0 || occupancy !== 3'd0 || upd_valid !== 1'b0 || underflow !== 1'b0)
      begin n_err++; $display("FAIL mis_flush2 got f%b r%b occ%0d v%b u%b want f1 r0 occ0 v0 u0", flush, pred_ready, occupancy, upd_valid, underflow); end
    n_chk++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL mis_pulse_width got %b want 0", mispredict); end
    cycle(0, 0, '0, 0, 0);
    n_chk++; if (flush !== 1'b0 || pred_ready !== 1'b1) begin n_err++; $display("FAIL mis_exit got f%b r%b want f0 r1", flush, pred_ready); end
    cycle(1, 1, 2'd3, 0, 0);
    n_chk++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL mis_push_after got occ%0d want 1", occupancy); end
    cycle(0, 0, '0, 1, 1);
    n_chk++; if (upd_hist !== 2'd3 || mispredict !== 1'b0) begin n_err++; $display("FAIL mis_drain got h%0d m%b want h3 m0", upd_hist, mispredict); end
  endtask

  task automatic test_back_to_back();
    logic [HIST_W-1:0] h;
    cycle(1, 1'($urandom), 2'd1, 0, 0);
    cycle(1, 1'($urandom), 2'd2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      h = HIST_W'($urandom);
      cycle(1, 1'($urandom), h, 1, m_q[0].taken);
      n_chk++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL b2b_occ[%0d] got %0d want 2", i, occupancy); end
      n_chk++; if (upd_valid !== 1'b1 || upd_hist !== e_upd_hist || mispredict !== 1'b0)
        begin n_err++; $display("FAIL b2b_upd[%0d] got v%b h%0d m%b want v1 h%0d m0", i, upd_valid, upd_hist, mispredict, e_upd_hist); end
    end
    while (m_q.size() > 0) cycle(0, 0, '0, 1, m_q[0].taken);
  endtask

  task automatic test_underflow();
    cycle(0, 0, '0, 1, 1);
    n_chk++; if (underflow !== 1'b1 || upd_valid !== 1'b0) begin n_err++; $display("FAIL underflow got u%b v%b want u1 v0", underflow, upd_valid); end
    cycle(0, 0, '0, 0, 0);
    n_chk++; if (underflow !== 1'b1) begin n_err++; $display("FAIL underflow_sticky got %b want 1", underflow); end
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, HIST_W'(i), 0, 0);
      cycle(0, 0, '0, 1, 1);
      for (int k = 0; k < FLUSH_CYC; k++) cycle(0, 0, '0, 0, 0);
    end
    n_chk++; if (mispred_cnt !== CNT_W'(exp_mcnt())) begin n_err++; $display("FAIL stats_mispred got %0d want %0d", mispred_cnt, exp_mcnt()); end
    n_chk++; if (branch_cnt !== CNT_W'(exp_bcnt())) begin n_err++; $display("FAIL stats_branch got %0d want %0d", branch_cnt, exp_bcnt()); end
  endtask

  task automatic test_reset_midflush();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, HIST_W'(i), 0, 0);
    cycle(0, 0, '0, 1, 0);
    n_chk++; if (flush !== 1'b1) begin n_err++; $display("FAIL midflush_pre got %b want 1", flush); end
    do_reset();
  endtask

  task automatic test_random();
    bit pv, rv, rt;
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom_range(3) != 0);
      rv = ($urandom_range(2) == 0);
      if (m_q.size() > 0 && $urandom_range(5) != 0) rt = m_q[0].taken;
      else rt = 1'($urandom);
      cycle(pv, 1'($urandom), HIST_W'($urandom), rv, rt);
      n_chk++;
      if (pred_ready !== m_ready() || occupancy !== 3'(m_q.size()) || flush !== (m_flush > 0) ||
          upd_valid !== e_upd_valid || mispredict !== e_mis || underflow !== m_under ||
          (e_upd_valid && (upd_hist !== e_upd_hist || upd_outcome !== e_upd_outcome)) ||
          branch_cnt !== CNT_W'(exp_bcnt()) || mispred_cnt !== CNT_W'(exp_mcnt())) begin
        n_err++;
        $display("FAIL rand[%0d] got r%b occ%0d f%b v%b m%b u%b h%0d o%b bc%0d mc%0d want r%b occ%0d f%b v%b m%b u%b h%0d o%b bc%0d mc%0d",
                 i, pred_ready, occupancy, flush, upd_valid, mispredict, underflow, upd_hist, upd_outcome, branch_cnt, mispred_cnt,
                 m_ready(), m_q.size(), (m_flush > 0), e_upd_valid, e_mis, m_under, e_upd_hist, e_upd_outcome, exp_bcnt(), exp_mcnt());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_correct_path();
    test_mispredict();
    test_back_to_back();
    test_underflow();
    test_stats();
    test_reset_midflush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
